// File: rtl/renkon_feeder_if.sv
// Word-stream, accelerator and result-stream signals of the renkon feeder.
// The feeder side uses the master modport; the environment side uses slave.
interface renkon_feeder_if #(
   parameter int DWIDTH  = 16,
   parameter int IMGSIZE = 12,
   parameter int NETSIZE = 11,
   parameter int CORELOG = 3,
   parameter int LWIDTH  = 10
);
   logic                     in_valid;
   logic signed [DWIDTH-1:0] in_data;
   logic                     in_ready;
   logic                     req;
   logic                     img_we;
   logic [IMGSIZE-1:0]       input_addr;
   logic [IMGSIZE-1:0]       output_addr;
   logic [DWIDTH-1:0]        write_img;
   logic [CORELOG:0]         net_we;
   logic [NETSIZE-1:0]       net_addr;
   logic [DWIDTH-1:0]        write_net;
   logic [LWIDTH-1:0]        total_out;
   logic [LWIDTH-1:0]        total_in;
   logic [LWIDTH-1:0]        img_size;
   logic [LWIDTH-1:0]        fil_size;
   logic [LWIDTH-1:0]        pool_size;
   logic                     ack;
   logic signed [DWIDTH-1:0] read_img;
   logic                     out_valid;
   logic [DWIDTH-1:0]        out_data;
   logic                     out_ready;

   modport master (
      input  in_valid, in_data, ack, read_img, out_ready,
      output in_ready, req, img_we, input_addr, output_addr, write_img,
             net_we, net_addr, write_net, total_out, total_in, img_size,
             fil_size, pool_size, out_valid, out_data
   );

   modport slave (
      output in_valid, in_data, ack, read_img, out_ready,
      input  in_ready, req, img_we, input_addr, output_addr, write_img,
             net_we, net_addr, write_net, total_out, total_in, img_size,
             fil_size, pool_size, out_valid, out_data
   );
endinterface

// File: rtl/renkon_feeder.sv
// Loads image and per-core weights into the accelerator, kicks one layer,
// then streams the result words back through a 2-entry output FIFO.
module renkon_feeder #(
   parameter int DWIDTH  = 16,
   parameter int IMGSIZE = 12,
   parameter int NETSIZE = 11,
   parameter int CORE    = 8,
   parameter int CORELOG = 3,
   parameter int LWIDTH  = 10
) (
   input  logic               clk,
   input  logic               xrst,
   input  logic               start,
   input  logic [IMGSIZE-1:0] img_len,
   input  logic [NETSIZE-1:0] net_len,
   input  logic [IMGSIZE-1:0] out_base,
   input  logic [IMGSIZE-1:0] out_len,
   input  logic [LWIDTH-1:0]  total_out_i,
   input  logic [LWIDTH-1:0]  total_in_i,
   input  logic [LWIDTH-1:0]  img_size_i,
   input  logic [LWIDTH-1:0]  fil_size_i,
   input  logic [LWIDTH-1:0]  pool_size_i,
   output logic               done,
   output logic               busy,
   renkon_feeder_if.master    bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_IMG, S_LOAD_NET, S_RUN, S_WAIT_ACK, S_READ, S_FLUSH
   } state_t;

   state_t              state_q, state_d;
   logic [IMGSIZE-1:0]  img_len_q, img_len_d, out_base_q, out_base_d;
   logic [IMGSIZE-1:0]  out_len_q, out_len_d;
   logic [NETSIZE-1:0]  net_len_q, net_len_d;
   logic [LWIDTH-1:0]   tout_q, tout_d, tin_q, tin_d, isz_q, isz_d;
   logic [LWIDTH-1:0]   fsz_q, fsz_d, psz_q, psz_d;
   logic [IMGSIZE-1:0]  img_cnt_q, img_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [NETSIZE-1:0]  net_addr_q, net_addr_d;
   logic [CORELOG-1:0]  core_q, core_d;
   logic                inflight_q, inflight_d;
   logic [DWIDTH-1:0]   fifo_q [2];
   logic [DWIDTH-1:0]   fifo_d [2];
   logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]          count_q, count_d;
   logic                done_q, done_d;

   logic                in_ready_s, img_we_s, req_s, push_s, pop_s;
   logic [CORELOG:0]    net_we_s;
   logic [IMGSIZE-1:0]  input_addr_s;
   logic [NETSIZE-1:0]  net_addr_s;
   logic [DWIDTH-1:0]   write_img_s, write_net_s;

   // Next-state, counters, FIFO and combinational handshake outputs.
   always_comb begin
      state_d      = state_q;
      img_len_d    = img_len_q;
      net_len_d    = net_len_q;
      out_base_d   = out_base_q;
      out_len_d    = out_len_q;
      tout_d       = tout_q;
      tin_d        = tin_q;
      isz_d        = isz_q;
      fsz_d        = fsz_q;
      psz_d        = psz_q;
      img_cnt_d    = img_cnt_q;
      net_addr_d   = net_addr_q;
      core_d       = core_q;
      rd_cnt_d     = rd_cnt_q;
      inflight_d   = 1'b0;
      done_d       = 1'b0;
      in_ready_s   = 1'b0;
      img_we_s     = 1'b0;
      net_we_s     = '0;
      req_s        = 1'b0;
      input_addr_s = '0;
      net_addr_s   = '0;
      write_img_s  = '0;
      write_net_s  = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               img_len_d  = img_len;
               net_len_d  = net_len;
               out_base_d = out_base;
               out_len_d  = out_len;
               tout_d     = total_out_i;
               tin_d      = total_in_i;
               isz_d      = img_size_i;
               fsz_d      = fil_size_i;
               psz_d      = pool_size_i;
               img_cnt_d  = '0;
               net_addr_d = '0;
               core_d     = '0;
               rd_cnt_d   = '0;
               state_d    = (img_len == '0) ? S_LOAD_NET : S_LOAD_IMG;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD_IMG: begin
            in_ready_s   = 1'b1;
            input_addr_s = img_cnt_q;
            if (bus.in_valid) begin
               img_we_s    = 1'b1;
               write_img_s = bus.in_data;
               img_cnt_d   = img_cnt_q + IMGSIZE'(1);
               state_d     = (img_cnt_q == img_len_q - IMGSIZE'(1)) ? S_LOAD_NET : S_LOAD_IMG;
            end else begin
               state_d = S_LOAD_IMG;
            end
         end
         S_LOAD_NET: begin
            net_addr_s = net_addr_q;
            if (net_len_q == '0) begin
               state_d = S_RUN;
            end else begin
               in_ready_s = 1'b1;
               if (bus.in_valid) begin
                  net_we_s    = {1'b0, core_q} + (CORELOG+1)'(1);
                  write_net_s = bus.in_data;
                  // Address wrap moves to the next core; the last core's wrap ends the load.
                  if (net_addr_q == net_len_q - NETSIZE'(1)) begin
                     net_addr_d = '0;
                     if (core_q == CORELOG'(CORE-1)) begin
                        state_d = S_RUN;
                     end else begin
                        core_d = core_q + CORELOG'(1);
                     end
                  end else begin
                     net_addr_d = net_addr_q + NETSIZE'(1);
                  end
               end else begin
                  state_d = S_LOAD_NET;
               end
            end
         end
         S_RUN: begin
            req_s   = 1'b1;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            state_d = bus.ack ? S_READ : S_WAIT_ACK;
         end
         S_READ: begin
            input_addr_s = out_base_q + rd_cnt_q;
            if (rd_cnt_q == out_len_q) begin
               state_d = S_FLUSH;
            end else if (({1'b0, inflight_q} + count_q) < 2'd2) begin
               inflight_d = 1'b1;
               rd_cnt_d   = rd_cnt_q + IMGSIZE'(1);
            end else begin
               inflight_d = 1'b0;
            end
         end
         S_FLUSH: begin
            if ((count_q == 2'd0) && !inflight_q) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_FLUSH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A read issued last cycle returns its word this cycle.
      push_s   = inflight_q;
      pop_s    = (count_q != 2'd0) && bus.out_ready;
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         fifo_d[wr_ptr_q] = bus.read_img;
         wr_ptr_d         = ~wr_ptr_q;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!xrst) begin
         state_q    <= S_IDLE;
         img_len_q  <= '0;
         net_len_q  <= '0;
         out_base_q <= '0;
         out_len_q  <= '0;
         tout_q     <= '0;
         tin_q      <= '0;
         isz_q      <= '0;
         fsz_q      <= '0;
         psz_q      <= '0;
         img_cnt_q  <= '0;
         net_addr_q <= '0;
         core_q     <= '0;
         rd_cnt_q   <= '0;
         inflight_q <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         img_len_q  <= img_len_d;
         net_len_q  <= net_len_d;
         out_base_q <= out_base_d;
         out_len_q  <= out_len_d;
         tout_q     <= tout_d;
         tin_q      <= tin_d;
         isz_q      <= isz_d;
         fsz_q      <= fsz_d;
         psz_q      <= psz_d;
         img_cnt_q  <= img_cnt_d;
         net_addr_q <= net_addr_d;
         core_q     <= core_d;
         rd_cnt_q   <= rd_cnt_d;
         inflight_q <= inflight_d;
         fifo_q[0]  <= fifo_d[0];
         fifo_q[1]  <= fifo_d[1];
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         done_q     <= done_d;
      end
   end

   assign done            = done_q;
   assign busy            = (state_q != S_IDLE);
   assign bus.in_ready    = in_ready_s;
   assign bus.req         = req_s;
   assign bus.img_we      = img_we_s;
   assign bus.input_addr  = input_addr_s;
   assign bus.output_addr = out_base_q;
   assign bus.write_img   = write_img_s;
   assign bus.net_we      = net_we_s;
   assign bus.net_addr    = net_addr_s;
   assign bus.write_net   = write_net_s;
   assign bus.total_out   = tout_q;
   assign bus.total_in    = tin_q;
   assign bus.img_size    = isz_q;
   assign bus.fil_size    = fsz_q;
   assign bus.pool_size   = psz_q;
   assign bus.out_valid   = (count_q != 2'd0);
   assign bus.out_data    = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_renkon_feeder.sv
// Directed bench for renkon_feeder: load sequencing, ack wait, wrapped
// read-back with back-pressure, ignored start, and mid-load reset.
module tb_renkon_feeder;
   logic        clk = 1'b0;
   logic        xrst, start;
   logic [11:0] img_len, out_base, out_len;
   logic [10:0] net_len;
   logic [9:0]  total_out_i, total_in_i, img_size_i, fil_size_i, pool_size_i;
   logic        done, busy;
   logic [15:0] src_idx;
   logic        log_clr;
   int          n_chk = 0;
   int          n_bad = 0;

   logic [11:0] img_a [$];
   logic [15:0] img_d [$];
   logic [3:0]  net_w [$];
   logic [10:0] net_a [$];
   logic [15:0] net_d [$];
   logic [15:0] out_q [$];
   int          n_req, n_done, viol, stab_viol;
   logic        prev_stall;
   logic [15:0] prev_data;

   renkon_feeder_if bus ();

   renkon_feeder dut (
      .clk(clk), .xrst(xrst), .start(start), .img_len(img_len), .net_len(net_len),
      .out_base(out_base), .out_len(out_len), .total_out_i(total_out_i),
      .total_in_i(total_in_i), .img_size_i(img_size_i), .fil_size_i(fil_size_i),
      .pool_size_i(pool_size_i), .done(done), .busy(busy), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rd_val(input logic [11:0] a);
      return {4'hA, a} ^ 16'h0055;
   endfunction

   assign bus.in_data = 16'h0100 + src_idx;

   // Accelerator image memory: one-cycle read latency.
   always @(posedge clk) bus.read_img <= rd_val(bus.input_addr);

   // Source word index advances on every accepted transfer.
   always @(posedge clk) begin
      if (!xrst || (start && !busy)) src_idx <= 16'd0;
      else if (bus.in_valid && bus.in_ready) src_idx <= src_idx + 16'd1;
   end

   // Mid-cycle monitor of writes, req/done pulses and the result stream.
   always @(negedge clk) begin
      if (log_clr) begin
         img_a.delete(); img_d.delete(); net_w.delete(); net_a.delete();
         net_d.delete(); out_q.delete();
         n_req <= 0; n_done <= 0; viol <= 0; stab_viol <= 0; prev_stall <= 1'b0;
      end else begin
         if (bus.img_we) begin
            img_a.push_back(bus.input_addr);
            img_d.push_back(bus.write_img);
         end
         if (bus.net_we != 4'd0) begin
            net_w.push_back(bus.net_we);
            net_a.push_back(bus.net_addr);
            net_d.push_back(bus.write_net);
         end
         if ((bus.img_we || bus.net_we != 4'd0) && !bus.in_valid) viol <= viol + 1;
         if (bus.req) n_req <= n_req + 1;
         if (done) n_done <= n_done + 1;
         if (prev_stall && (!bus.out_valid || bus.out_data != prev_data)) stab_viol <= stab_viol + 1;
         prev_stall <= bus.out_valid && !bus.out_ready;
         prev_data  <= bus.out_data;
         if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      log_clr = 1'b1;
      tick();
      log_clr = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
   endtask

   task automatic wait_req(input int budget);
      int k = 0;
      while (n_req == 0 && k < budget) begin
         tick();
         k++;
      end
      tick();
      check_eq("req_once", n_req, 1);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (n_done == 0 && k < budget) begin
         tick();
         k++;
      end
      tick();
      check_eq("done_once", n_done, 1);
   endtask

   initial begin
      xrst = 1'b0; start = 1'b0; log_clr = 1'b0;
      img_len = 12'd0; net_len = 11'd0; out_base = 12'd0; out_len = 12'd0;
      total_out_i = 10'd0; total_in_i = 10'd0; img_size_i = 10'd0;
      fil_size_i = 10'd0; pool_size_i = 10'd0;
      bus.in_valid = 1'b0; bus.ack = 1'b0; bus.out_ready = 1'b1;
      repeat (3) tick();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_in_ready", bus.in_ready, 0);
      check_eq("rst_req", bus.req, 0);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_input_addr", bus.input_addr, 0);
      check_eq("rst_out_data", bus.out_data, 0);
      xrst = 1'b1;
      clear_logs();

      // Basic load order, parameter hold and delayed ack.
      img_len = 12'd4; net_len = 11'd2; out_base = 12'd10; out_len = 12'd3;
      total_out_i = 10'd5; total_in_i = 10'd7; img_size_i = 10'd28;
      fil_size_i = 10'd3; pool_size_i = 10'd2;
      bus.in_valid = 1'b1;
      pulse_start();
      total_out_i = 10'd99; fil_size_i = 10'd9; out_base = 12'd77;
      wait_req(100);
      bus.in_valid = 1'b0;
      check_eq("img_cnt", img_a.size(), 4);
      for (int k = 0; k < 4 && k < img_a.size(); k++) begin
         check_eq("img_addr", img_a[k], k);
         check_eq("img_data", img_d[k], 32'h100 + k);
      end
      check_eq("net_cnt", net_w.size(), 16);
      for (int k = 0; k < 16 && k < net_w.size(); k++) begin
         check_eq("net_we", net_w[k], k / 2 + 1);
         check_eq("net_addr", net_a[k], k % 2);
         check_eq("net_data", net_d[k], 32'h104 + k);
      end
      check_eq("total_out_held", bus.total_out, 5);
      check_eq("fil_size_held", bus.fil_size, 3);
      check_eq("output_addr", bus.output_addr, 10);
      repeat (50) tick();
      check_eq("req_still_once", n_req, 1);
      check_eq("no_read_before_ack", out_q.size(), 0);
      check_eq("busy_wait_ack", busy, 1);
      check_eq("addr_wait_ack", bus.input_addr, 0);
      pulse_ack();
      check_eq("read_first_addr", bus.input_addr, 10);
      wait_done(200);
      check_eq("out_cnt1", out_q.size(), 3);
      for (int k = 0; k < 3 && k < out_q.size(); k++) check_eq("out_data1", out_q[k], rd_val(12'd10 + 12'(k)));
      check_eq("idle_after_done", busy, 0);
      clear_logs();

      // Toggled in_valid, out_len of zero.
      img_len = 12'd3; net_len = 11'd1; out_base = 12'd5; out_len = 12'd0;
      pulse_start();
      for (int c = 0; c < 60 && n_req == 0; c++) begin
         bus.in_valid = c[0];
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      check_eq("t2_img_cnt", img_a.size(), 3);
      for (int k = 0; k < 3 && k < img_a.size(); k++) begin
         check_eq("t2_img_addr", img_a[k], k);
         check_eq("t2_img_data", img_d[k], 32'h100 + k);
      end
      check_eq("t2_net_cnt", net_w.size(), 8);
      for (int k = 0; k < 8 && k < net_w.size(); k++) begin
         check_eq("t2_net_we", net_w[k], k + 1);
         check_eq("t2_net_addr", net_a[k], 0);
         check_eq("t2_net_data", net_d[k], 32'h103 + k);
      end
      check_eq("t2_write_without_valid", viol, 0);
      pulse_ack();
      wait_done(50);
      check_eq("t2_no_output", out_q.size(), 0);
      clear_logs();

      // Address wrap, back-pressure, start ignored while busy.
      img_len = 12'd0; net_len = 11'd0; out_base = 12'd4094; out_len = 12'd4;
      pulse_start();
      wait_req(20);
      pulse_ack();
      tick();
      bus.out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      bus.out_ready = 1'b1;
      wait_done(100);
      repeat (10) tick();
      check_eq("t3_out_cnt", out_q.size(), 4);
      for (int k = 0; k < 4 && k < out_q.size(); k++) check_eq("t3_out_data", out_q[k], rd_val(12'd4094 + 12'(k)));
      check_eq("t3_single_done", n_done, 1);
      check_eq("t3_stall_stable", stab_viol, 0);
      check_eq("t3_single_req", n_req, 1);
      check_eq("t3_idle", busy, 0);
      clear_logs();

      // Reset during the weight load, then a clean restart.
      img_len = 12'd2; net_len = 11'd3; out_base = 12'd100; out_len = 12'd1;
      total_out_i = 10'd33;
      bus.in_valid = 1'b1;
      pulse_start();
      for (int c = 0; c < 50 && net_w.size() < 2; c++) tick();
      check_eq("t4_in_load_net", net_w.size(), 2);
      xrst = 1'b0;
      tick();
      check_eq("t4_busy", busy, 0);
      check_eq("t4_in_ready", bus.in_ready, 0);
      check_eq("t4_net_we", bus.net_we, 0);
      check_eq("t4_img_we", bus.img_we, 0);
      check_eq("t4_output_addr", bus.output_addr, 0);
      check_eq("t4_total_out", bus.total_out, 0);
      check_eq("t4_net_addr", bus.net_addr, 0);
      xrst = 1'b1;
      clear_logs();
      net_len = 11'd1;
      pulse_start();
      wait_req(100);
      bus.in_valid = 1'b0;
      check_eq("t4_img_cnt", img_a.size(), 2);
      if (img_a.size() > 0) begin
         check_eq("t4_img_addr0", img_a[0], 0);
         check_eq("t4_img_data0", img_d[0], 32'h100);
      end
      check_eq("t4_net_cnt", net_w.size(), 8);
      pulse_ack();
      wait_done(100);
      check_eq("t4_out_cnt", out_q.size(), 1);
      if (out_q.size() > 0) check_eq("t4_out_data", out_q[0], rd_val(12'd100));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
